ex_hazard_ctrl: RTL

EX_HAZARD_CTRL -- requirements
Module: ex_hazard_ctrl

---
 rtl/ex_hazard_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl -- pipeline hazard controller for the EX stage.
//
// Resolves four hazard sources, highest priority first: Dcache miss,
// multi-cycle EX op (div / SIMD mul), taken branch, load-use. Stall, flush
// and bubble outputs are combinational from the FSM state and the current
// inputs, so the pipeline reacts in the same cycle. Multi-cycle waits are
// bounded by a timeout counter that raises a one-cycle error pulse.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   ID_Rs{1,2,3}Addr, ID_RsValid source regs of the ID instruction
//   IDEX_RdAddr, IDEX_MemRdEN   destination / load flag of the EX instruction
//   MC_Start, MC_Done           multi-cycle unit handshake
//   Mem_Req, Dcache_Ready       MEM-stage Dcache access / completion
//   EX_BranchTaken              EX redirects the PC
//   Hazard_*Stall / *Flush      stage register hold / bubble controls
//   Hazard_EXMemBubble          bubble into EX/MEM while EX is busy
//   Hazard_State                current FSM state
//   Hazard_MCTimeout            registered one-cycle timeout pulse
//   Hazard_StallCnt             saturating count of PC-stall cycles
module ex_hazard_ctrl #(
    parameter int RF_ADDR_WIDTH = 5,
    parameter int MC_MAX_CYCLES = 34
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [RF_ADDR_WIDTH-1:0] ID_Rs1Addr,
    input  logic [RF_ADDR_WIDTH-1:0] ID_Rs2Addr,
    input  logic [RF_ADDR_WIDTH-1:0] ID_Rs3Addr,
    input  logic [2:0]               ID_RsValid,
    input  logic [RF_ADDR_WIDTH-1:0] IDEX_RdAddr,
    input  logic                     IDEX_MemRdEN,
    input  logic                     MC_Start,
    input  logic                     MC_Done,
    input  logic                     Mem_Req,
    input  logic                     Dcache_Ready,
    input  logic                     EX_BranchTaken,
    output logic                     Hazard_PCStall,
    output logic                     Hazard_IFIDStall,
    output logic                     Hazard_IDEXStall,
    output logic                     Hazard_EXMemStall,
    output logic                     Hazard_IFIDFlush,
    output logic                     Hazard_IDEXFlush,
    output logic                     Hazard_EXMemBubble,
    output logic [1:0]               Hazard_State,
    output logic                     Hazard_MCTimeout,
    output logic [15:0]              Hazard_StallCnt
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        MISSWAIT = 2'b01,
        MCWAIT   = 2'b10,
        ILLEGAL  = 2'b11
    } state_e;

    localparam logic [7:0] MC_LAST = 8'(MC_MAX_CYCLES - 1);

    state_e      state_q, state_d;
    logic [7:0]  mc_cnt_q, mc_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        mc_timeout_q, mc_timeout_d;
    logic        miss, load_use;

    assign miss = Mem_Req && !Dcache_Ready;

    // x0 is hardwired zero, so a load targeting it never creates a dependency.
    assign load_use = IDEX_MemRdEN && (IDEX_RdAddr != '0) &&
                      ((ID_RsValid[0] && (ID_Rs1Addr == IDEX_RdAddr)) ||
                       (ID_RsValid[1] && (ID_Rs2Addr == IDEX_RdAddr)) ||
                       (ID_RsValid[2] && (ID_Rs3Addr == IDEX_RdAddr)));

    always_comb begin
        state_d            = state_q;
        mc_cnt_d           = mc_cnt_q;
        mc_timeout_d       = 1'b0;
        Hazard_PCStall     = 1'b0;
        Hazard_IFIDStall   = 1'b0;
        Hazard_IDEXStall   = 1'b0;
        Hazard_EXMemStall  = 1'b0;
        Hazard_IFIDFlush   = 1'b0;
        Hazard_IDEXFlush   = 1'b0;
        Hazard_EXMemBubble = 1'b0;
        case (state_q)
            IDLE: begin
                if (miss) begin
                    {Hazard_PCStall, Hazard_IFIDStall,
                     Hazard_IDEXStall, Hazard_EXMemStall} = 4'b1111;
                    state_d = MISSWAIT;
                end else if (MC_Start && !MC_Done) begin
                    {Hazard_PCStall, Hazard_IFIDStall, Hazard_IDEXStall} = 3'b111;
                    Hazard_EXMemBubble = 1'b1;
                    state_d            = MCWAIT;
                    mc_cnt_d           = '0;
                end else if (EX_BranchTaken) begin
                    // The flush kills the ID instruction, so a load-use match is moot.
                    Hazard_IFIDFlush = 1'b1;
                    Hazard_IDEXFlush = 1'b1;
                end else if (load_use) begin
                    Hazard_PCStall   = 1'b1;
                    Hazard_IFIDStall = 1'b1;
                    Hazard_IDEXFlush = 1'b1;
                end
            end
            MISSWAIT: begin
                if (!Dcache_Ready) begin
                    {Hazard_PCStall, Hazard_IFIDStall,
                     Hazard_IDEXStall, Hazard_EXMemStall} = 4'b1111;
                end else begin
                    state_d = IDLE;
                end
            end
            MCWAIT: begin
                // EX is frozen here, so a taken branch is re-presented after release.
                if (MC_Done) begin
                    state_d  = IDLE;
                    mc_cnt_d = '0;
                end else begin
                    {Hazard_PCStall, Hazard_IFIDStall, Hazard_IDEXStall} = 3'b111;
                    Hazard_EXMemBubble = 1'b1;
                    if (mc_cnt_q == MC_LAST) begin
                        mc_timeout_d = 1'b1;
                        state_d      = IDLE;
                        mc_cnt_d     = '0;
                    end else begin
                        mc_cnt_d = mc_cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Hazard controls are quiet throughout reset, whatever the inputs do.
        if (!rst_n) begin
            Hazard_PCStall     = 1'b0;
            Hazard_IFIDStall   = 1'b0;
            Hazard_IDEXStall   = 1'b0;
            Hazard_EXMemStall  = 1'b0;
            Hazard_IFIDFlush   = 1'b0;
            Hazard_IDEXFlush   = 1'b0;
            Hazard_EXMemBubble = 1'b0;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (Hazard_PCStall && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mc_cnt_q     <= '0;
            stall_cnt_q  <= '0;
            mc_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mc_cnt_q     <= mc_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            mc_timeout_q <= mc_timeout_d;
        end
    end

    assign Hazard_State     = state_q;
    assign Hazard_MCTimeout = mc_timeout_q;
    assign Hazard_StallCnt  = stall_cnt_q;

endmodule
